darkpc_mt: RTL
==============

Name: darkpc_mt

Overview:
- Multi-thread program-counter unit for the darkriscv fetch stage.
- Holds one PC per hardware thread and round-robins fetch between threads on each enabled cycle.
- Auto-increments the fetched thread's PC by 4, or applies a per-thread redirect from execute (branch/jump).
- Generalises the single-PC register to THREADS channels, with a configurable reset layout and optional misaligned-target trapping.

Parameters:
- XLEN, 32, PC width in bits.
- THREADS, 2, number of hardware threads (1..16).
- RESET_PC, 32'h0000_0000, reset PC of thread 0.
- RESET_STRIDE, 32'h0000_1000, reset offset between threads: thread t resets to RESET_PC + t*RESET_STRIDE.
- TRAP_VEC, 32'h0000_0100, target loaded on a misaligned redirect (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  asynchronous active-high reset.
- en  in  1  fetch advance (pipeline not stalled).
- tid  out  TW  thread currently fetching; TW = max(1, $clog2(THREADS)).
- pc  out  XLEN  PC of thread tid.
- nxpc_vld  in  1  redirect request.
- nxpc_tid  in  TW  thread targeted by the redirect.
- nxpc  in  XLEN  redirect target.
- misalign  out  1  one-cycle pulse: a misaligned redirect was trapped.
- badpc  out  XLEN  last misaligned redirect target.

Behaviour:
- Reset (async assert, sync deassert at the clk edge after res falls):
  - pcff[t] = RESET_PC + t*RESET_STRIDE, computed mod 2^XLEN.
  - tid = 0, misalign = 0, badpc = 0.
- Output timing:
  - pc = pcff[tid], combinational from registers; no input-to-output combinational path.
  - Fetch latency is 0 cycles: pc is valid in the same cycle tid is shown.
- Thread rotation:
  - On a clk edge with en=1, tid <= (tid == THREADS-1) ? 0 : tid+1.
  - With en=0, tid holds.
  - THREADS=1: tid is constant 0.
- Increment:
  - On a clk edge with en=1, pcff[tid] <= pcff[tid] + 4.
  - Wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0); the carry is dropped.
- Redirect:
  - On a clk edge with nxpc_vld=1 and nxpc_tid < THREADS, pcff[nxpc_tid] <= nxpc. This applies regardless of en, so a stalled pipeline still accepts redirects.
  - If nxpc_tid >= THREADS, the redirect is ignored with no state change.
- Simultaneous events:
  - Redirect and increment hitting the same thread (en=1, nxpc_tid == tid): the redirect wins and the increment is discarded.
  - Redirect and increment hitting different threads: both take effect in the same cycle.
  - The tid rotation is unaffected by redirects.
- One redirect per cycle; no handshake back-pressure. The redirect is always accepted.
- Other threads' PCs are never touched by an enabled cycle.
- Reset mid-operation: all state returns to its reset values immediately, regardless of en or nxpc_vld.

Optional Feature:
- Macro: DARKPC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with nxpc[1:0] != 0 loads TRAP_VEC into pcff[nxpc_tid] instead of nxpc.
  - badpc <= nxpc.
  - misalign is a registered pulse: high for exactly one cycle after the trapping edge.
  - Back-to-back misaligned redirects produce a pulse every cycle; badpc tracks the latest target.
  - The aligned-redirect path is unchanged.
- Undefined:
  - nxpc[1:0] is forced to 2'b00 on every redirect.
  - misalign is tied 0 and badpc is tied 0; no trap logic is synthesised.

Test Plan:
- Reset with THREADS=2, then en=1 for 4 cycles -> (tid, pc) sequence is (0, 0x0), (1, 0x1000), (0, 0x4), (1, 0x1004).
- en=0 for 3 cycles after reset -> tid stays 0, pc stays 0x0; then nxpc_vld=1, nxpc_tid=1, nxpc=0x2000 while en=0 -> next time tid=1, pc=0x2000.
- en=1, tid=0, nxpc_vld=1, nxpc_tid=0, nxpc=0x80 in the same cycle -> pcff[0]=0x80, not 0x4; pcff[1] unchanged at 0x1000.
- Set pcff[0]=0xFFFF_FFFC via redirect, then en=1 on tid 0 -> pcff[0] wraps to 0x0; also nxpc_tid=3 with THREADS=2 -> no register changes.
- With DARKPC_MISALIGN_TRAP_EN defined, redirect nxpc=0x1002 to thread 1 -> pcff[1]=0x100, badpc=0x1002, misalign high for exactly one cycle. Without the macro -> pcff[1]=0x1000, misalign stays 0.
- Assert res asynchronously mid-cycle while en=1 and nxpc_vld=1 -> outputs go to tid=0, pc=0x0, misalign=0 before the next clk edge, and state stays at reset until res deasserts.

Source files
------------

// File: rtl/darkpc_mt.sv
// Multi-thread program counter for the darkriscv fetch stage: one PC per thread, round-robin fetch.
// Optional misaligned-redirect trap enabled by defining DARKPC_MISALIGN_TRAP_EN.
module darkpc_mt #(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     THREADS      = 2,
   parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
   parameter logic [XLEN-1:0] RESET_STRIDE = 32'h0000_1000,
   parameter logic [XLEN-1:0] TRAP_VEC     = 32'h0000_0100,
   localparam int unsigned    TW           = (THREADS > 1) ? $clog2(THREADS) : 1
) (
   input  logic            clk,
   input  logic            res,
   input  logic            en,
   output logic [TW-1:0]   tid,
   output logic [XLEN-1:0] pc,
   input  logic            nxpc_vld,
   input  logic [TW-1:0]   nxpc_tid,
   input  logic [XLEN-1:0] nxpc,
   output logic            misalign,
   output logic [XLEN-1:0] badpc
);

   logic [XLEN-1:0] pcff_q [THREADS];
   logic [XLEN-1:0] pcff_d [THREADS];
   logic [TW-1:0]   tid_q;
   logic [TW-1:0]   tid_d;
   logic            redir_ok;
   logic [XLEN-1:0] redir_pc;

   // Redirects naming a thread that does not exist are dropped.
   assign redir_ok = nxpc_vld && (32'(nxpc_tid) < THREADS);

   assign tid_d = (32'(tid_q) == THREADS - 1) ? '0 : tid_q + TW'(1);

   // Redirect has priority over the increment when both target the same thread.
   always_comb begin
      pcff_d = pcff_q;
      for (int t = 0; t < THREADS; t++) begin
         if (redir_ok && nxpc_tid == TW'(t)) begin
            pcff_d[t] = redir_pc;
         end else if (en && tid_q == TW'(t)) begin
            pcff_d[t] = pcff_q[t] + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         tid_q <= '0;
         for (int t = 0; t < THREADS; t++) begin
            pcff_q[t] <= RESET_PC + XLEN'(t) * RESET_STRIDE;
         end
      end else begin
         if (en) begin
            tid_q <= tid_d;
         end
         for (int t = 0; t < THREADS; t++) begin
            pcff_q[t] <= pcff_d[t];
         end
      end
   end

   always_comb begin
      pc = '0;
      for (int t = 0; t < THREADS; t++) begin
         if (tid_q == TW'(t)) begin
            pc = pcff_q[t];
         end
      end
   end

   assign tid = tid_q;

`ifdef DARKPC_MISALIGN_TRAP_EN
   logic            mis;
   logic            misalign_q;
   logic [XLEN-1:0] badpc_q;

   assign mis      = nxpc[1:0] != 2'b00;
   assign redir_pc = mis ? TRAP_VEC : nxpc;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         misalign_q <= 1'b0;
         badpc_q    <= '0;
      end else begin
         misalign_q <= redir_ok && mis;
         if (redir_ok && mis) begin
            badpc_q <= nxpc;
         end
      end
   end

   assign misalign = misalign_q;
   assign badpc    = badpc_q;
`else
   // Low bits are forced to zero so every PC stays word aligned.
   assign redir_pc = nxpc & ~XLEN'(3);
   assign misalign = 1'b0;
   assign badpc    = '0;
`endif

endmodule
